vga_capture: RTL and testbench
==============================

Name: vga_capture

Overview:
- Receive-side counterpart of the VGA output path.
- Samples a parallel VGA pixel stream (hsync, vsync, blank_n, 24-bit RGB) in the pixel clock domain and reconstructs horizontal/vertical pixel addresses.
- Emits one write per active pixel to a frame memory with the same addressing as the VGA frame memory (10-bit h, 9-bit v, 24-bit data).
- Checks frame geometry and reports lock/error status. Used for loopback verification of the display pipeline and for frame capture.

Parameters:
- H_ACTIVE, 640, active pixels per line.
- V_ACTIVE, 480, active lines per frame.
- SYNC_ACTIVE_LOW, 1, 1: hsync/vsync asserted when 0; 0: asserted when 1.

Ports:
- i_clk  input  1  pixel clock
- i_rst  input  1  reset
- i_vga_hsync  input  1  horizontal sync
- i_vga_vsync  input  1  vertical sync
- i_vga_blank_n  input  1  1 = active pixel
- i_vga_r  input  8  red
- i_vga_g  input  8  green
- i_vga_b  input  8  blue
- o_wr_en  output  1  frame-memory write strobe
- o_wr_h_addr  output  10  pixel column
- o_wr_v_addr  output  9  pixel row
- o_wr_data  output  24  {r,g,b}
- o_frame_done  output  1  one-cycle pulse at end of each captured frame
- o_frame_err  output  1  geometry error status of last completed frame
- o_locked  output  1  last completed frame had exact geometry

Behaviour:
- Clocking and reset: one clock, i_clk. Reset i_rst is synchronous, active-high. While i_rst=1 at a rising edge, all registers and outputs clear to 0 and the FSM enters S_SEARCH.
- Input stage: all VGA inputs registered once. Sync inputs normalised to internal active-high vs/hs per SYNC_ACTIVE_LOW. Edges are detected against the previous registered value.
- S_SEARCH: no writes. On a vs rising edge (vsync assertion), go to S_VSYNC. The partial frame seen after reset is never written.
- S_VSYNC:
  - Clear h_cnt, v_cnt and per-frame error flag.
  - No writes.
  - When vs deasserts, go to S_ACTIVE.
- S_ACTIVE, each cycle with registered blank_n=1:
  - If h_cnt<H_ACTIVE and v_cnt<V_ACTIVE, write with o_wr_h_addr=h_cnt, o_wr_v_addr=v_cnt, o_wr_data={r,g,b}.
  - Otherwise suppress the write and set the error flag.
  - h_cnt increments, saturating at H_ACTIVE.
- End of active line (blank_n falling edge):
  - If h_cnt!=H_ACTIVE, set the error flag.
  - Clear h_cnt; v_cnt increments, saturating at V_ACTIVE.
- blank_n=1 while hs or vs asserted: set error flag; the pixel is still handled per the counter rules.
- Frame end (vs rising edge in S_ACTIVE):
  - If v_cnt!=V_ACTIVE, set the error flag.
  - Pulse o_frame_done for 1 cycle.
  - Load o_frame_err with the error flag; o_locked = !error flag.
  - Go to S_VSYNC.
- Simultaneous blank_n falling edge and vs rising edge: the line-end check is applied first, then the frame-end check.
- Latency: a pixel presented at edge k appears on the o_wr_* outputs after edge k+1 (2 registers). o_wr_en is 0 in all states except S_ACTIVE.
- o_frame_err and o_locked hold their values between frame ends. They change only at a frame end or on reset.
- Reset mid-frame: outputs clear immediately; no writes until a full vsync assert/deassert sequence has been seen.

Optional Feature:
- Macro VGA_CAPTURE_CHECKSUM_EN.
- Defined:
  - Adds output o_frame_sum [23:0]: modulo-2^24 sum of o_wr_data over all writes of a frame.
  - Accumulator clears in S_VSYNC.
  - Value latched to o_frame_sum on the cycle o_frame_done pulses; reset value 0.
- Undefined: port, accumulator and logic absent; all other behaviour identical.

Test Plan:
- Reset: assert i_rst for 3 cycles mid-stream -> all outputs 0. No o_wr_en until the next vsync assert+deassert.
- Nominal frame, H_ACTIVE=8, V_ACTIVE=4, data = v*16+h -> partial first frame produces 0 writes. Next frame produces 32 writes in raster order (h 0..7 per v 0..3), each exactly 2 cycles after input, with correct data. o_frame_done pulses once; o_frame_err=0, o_locked=1.
- Short line: line 2 has 7 active pixels -> 7 writes for v=2. At frame end o_frame_err=1, o_locked=0. A following clean frame restores o_locked=1.
- Long line / extra line: 9 pixels on line 0 and a 5th active line -> 9th pixel and all of line 5 produce no write. o_frame_err=1.
- Blank_n high during hsync assertion -> o_frame_err=1 at that frame end. Polarity: SYNC_ACTIVE_LOW=0 with inverted syncs -> identical write sequence to the nominal case.
- With VGA_CAPTURE_CHECKSUM_EN, nominal frame of all pixels 24'h000001 -> o_frame_sum=32 when o_frame_done pulses. Pixels 24'hFFFFFF x2 -> sum wraps to 24'hFFFFFE.

Source files
------------

// File: rtl/vga_capture.sv
// vga_capture: receive side of the VGA output path. Registers the incoming pixel
// stream, rebuilds column/row addresses, emits one frame-memory write per active
// pixel and reports per-frame geometry errors and lock status.
// Optional feature: define VGA_CAPTURE_CHECKSUM_EN to add o_frame_sum, the
// modulo-2^24 sum of all write data of the last completed frame.
module vga_capture #(
  parameter int unsigned H_ACTIVE        = 640,
  parameter int unsigned V_ACTIVE        = 480,
  parameter bit          SYNC_ACTIVE_LOW = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_vga_hsync,
  input  logic        i_vga_vsync,
  input  logic        i_vga_blank_n,
  input  logic [7:0]  i_vga_r,
  input  logic [7:0]  i_vga_g,
  input  logic [7:0]  i_vga_b,
  output logic        o_wr_en,
  output logic [9:0]  o_wr_h_addr,
  output logic [8:0]  o_wr_v_addr,
  output logic [23:0] o_wr_data,
  output logic        o_frame_done,
  output logic        o_frame_err,
`ifdef VGA_CAPTURE_CHECKSUM_EN
  output logic [23:0] o_frame_sum,
`endif
  output logic        o_locked
);

  // Counters must be able to hold the saturation value itself.
  localparam int unsigned HW = $clog2(H_ACTIVE + 1);
  localparam int unsigned VW = $clog2(V_ACTIVE + 1);
  localparam logic [HW-1:0] H_LIM = HW'(H_ACTIVE);
  localparam logic [VW-1:0] V_LIM = VW'(V_ACTIVE);

  typedef enum logic [1:0] {
    S_SEARCH = 2'd0,
    S_VSYNC  = 2'd1,
    S_ACTIVE = 2'd2
  } state_t;

  // Input stage
  logic          r_hs, r_vs, r_blank_n, r_vs_prev, r_blank_prev;
  logic [23:0]   r_rgb;
  logic          w_hs_norm, w_vs_norm, w_vs_rise, w_blank_fall;

  // Capture state
  state_t        r_state, w_state_d;
  logic [HW-1:0] r_h_cnt, w_h_cnt_d;
  logic [VW-1:0] r_v_cnt, w_v_cnt_d;
  logic          r_err, w_err_d;

  // Output registers
  logic          r_wr_en, w_wr_en_d;
  logic [9:0]    r_wr_h_addr, w_wr_h_addr_d;
  logic [8:0]    r_wr_v_addr, w_wr_v_addr_d;
  logic [23:0]   r_wr_data, w_wr_data_d;
  logic          r_frame_done, w_frame_done_d;
  logic          r_frame_err, w_frame_err_d;
  logic          r_locked, w_locked_d;
`ifdef VGA_CAPTURE_CHECKSUM_EN
  logic [23:0]   r_sum, w_sum_d;
  logic [23:0]   r_frame_sum, w_frame_sum_d;
`endif

  // Internal syncs are active-high regardless of pin polarity.
  assign w_hs_norm    = SYNC_ACTIVE_LOW ? ~i_vga_hsync : i_vga_hsync;
  assign w_vs_norm    = SYNC_ACTIVE_LOW ? ~i_vga_vsync : i_vga_vsync;
  assign w_vs_rise    = r_vs & ~r_vs_prev;
  assign w_blank_fall = r_blank_prev & ~r_blank_n;

  // Register the raw VGA inputs once and keep the previous values for edge detection.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_hs         <= 1'b0;
      r_vs         <= 1'b0;
      r_blank_n    <= 1'b0;
      r_rgb        <= '0;
      r_vs_prev    <= 1'b0;
      r_blank_prev <= 1'b0;
    end else begin
      r_hs         <= w_hs_norm;
      r_vs         <= w_vs_norm;
      r_blank_n    <= i_vga_blank_n;
      r_rgb        <= {i_vga_r, i_vga_g, i_vga_b};
      r_vs_prev    <= r_vs;
      r_blank_prev <= r_blank_n;
    end
  end

  // Next-state, counter, error-flag and write decode for the capture FSM.
  always_comb begin
    w_state_d      = r_state;
    w_h_cnt_d      = r_h_cnt;
    w_v_cnt_d      = r_v_cnt;
    w_err_d        = r_err;
    w_wr_en_d      = 1'b0;
    w_wr_h_addr_d  = r_wr_h_addr;
    w_wr_v_addr_d  = r_wr_v_addr;
    w_wr_data_d    = r_wr_data;
    w_frame_done_d = 1'b0;
    w_frame_err_d  = r_frame_err;
    w_locked_d     = r_locked;
`ifdef VGA_CAPTURE_CHECKSUM_EN
    w_sum_d        = r_sum;
    w_frame_sum_d  = r_frame_sum;
`endif
    unique case (r_state)
      S_SEARCH: begin
        if (w_vs_rise) w_state_d = S_VSYNC;
      end
      S_VSYNC: begin
        w_h_cnt_d = '0;
        w_v_cnt_d = '0;
        w_err_d   = 1'b0;
`ifdef VGA_CAPTURE_CHECKSUM_EN
        w_sum_d   = '0;
`endif
        if (!r_vs) w_state_d = S_ACTIVE;
      end
      S_ACTIVE: begin
        if (r_blank_n) begin
          if ((r_h_cnt < H_LIM) && (r_v_cnt < V_LIM)) begin
            w_wr_en_d     = 1'b1;
            w_wr_h_addr_d = 10'(r_h_cnt);
            w_wr_v_addr_d = 9'(r_v_cnt);
            w_wr_data_d   = r_rgb;
`ifdef VGA_CAPTURE_CHECKSUM_EN
            w_sum_d       = r_sum + r_rgb;
`endif
          end else begin
            w_err_d = 1'b1;
          end
          // Active video must never overlap a sync pulse.
          if (r_hs || r_vs) w_err_d = 1'b1;
          if (r_h_cnt != H_LIM) w_h_cnt_d = r_h_cnt + 1'b1;
        end
        // Line end is resolved before frame end so a coincident vsync sees the new row count.
        if (w_blank_fall) begin
          if (r_h_cnt != H_LIM) w_err_d = 1'b1;
          w_h_cnt_d = '0;
          if (r_v_cnt != V_LIM) w_v_cnt_d = r_v_cnt + 1'b1;
        end
        if (w_vs_rise) begin
          if (w_v_cnt_d != V_LIM) w_err_d = 1'b1;
          w_frame_done_d = 1'b1;
          w_frame_err_d  = w_err_d;
          w_locked_d     = ~w_err_d;
`ifdef VGA_CAPTURE_CHECKSUM_EN
          w_frame_sum_d  = w_sum_d;
`endif
          w_state_d      = S_VSYNC;
        end
      end
      default: w_state_d = S_SEARCH;
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= S_SEARCH;
      r_h_cnt      <= '0;
      r_v_cnt      <= '0;
      r_err        <= 1'b0;
      r_wr_en      <= 1'b0;
      r_wr_h_addr  <= '0;
      r_wr_v_addr  <= '0;
      r_wr_data    <= '0;
      r_frame_done <= 1'b0;
      r_frame_err  <= 1'b0;
      r_locked     <= 1'b0;
`ifdef VGA_CAPTURE_CHECKSUM_EN
      r_sum        <= '0;
      r_frame_sum  <= '0;
`endif
    end else begin
      r_state      <= w_state_d;
      r_h_cnt      <= w_h_cnt_d;
      r_v_cnt      <= w_v_cnt_d;
      r_err        <= w_err_d;
      r_wr_en      <= w_wr_en_d;
      r_wr_h_addr  <= w_wr_h_addr_d;
      r_wr_v_addr  <= w_wr_v_addr_d;
      r_wr_data    <= w_wr_data_d;
      r_frame_done <= w_frame_done_d;
      r_frame_err  <= w_frame_err_d;
      r_locked     <= w_locked_d;
`ifdef VGA_CAPTURE_CHECKSUM_EN
      r_sum        <= w_sum_d;
      r_frame_sum  <= w_frame_sum_d;
`endif
    end
  end

  assign o_wr_en      = r_wr_en;
  assign o_wr_h_addr  = r_wr_h_addr;
  assign o_wr_v_addr  = r_wr_v_addr;
  assign o_wr_data    = r_wr_data;
  assign o_frame_done = r_frame_done;
  assign o_frame_err  = r_frame_err;
  assign o_locked     = r_locked;
`ifdef VGA_CAPTURE_CHECKSUM_EN
  assign o_frame_sum  = r_frame_sum;
`endif

endmodule

// File: tb/tb_vga_capture.sv
// tb_vga_capture: drives a small-geometry (8x4) VGA stream into two instances,
// one with active-low syncs and one with active-high syncs fed inverted pins.
// Expected writes and frame results are queued as stimulus is driven and compared
// as each instance produces them.
module tb_vga_capture;
  localparam int HA = 8;
  localparam int VA = 4;

  typedef struct packed {
    logic [9:0]  h;
    logic [8:0]  v;
    logic [23:0] d;
    int unsigned cyc;
  } wr_t;

  typedef struct packed {
    logic        err;
    logic [23:0] sum;
    int unsigned cyc;
  } fr_t;

  // One frame of stimulus: line lengths, hsync overlap on line 1, data pattern, expected error.
  typedef struct packed {
    logic [3:0]      nlines;
    logic [5:0][3:0] npix;
    logic            hs_ovl;
    logic [1:0]      mode;
    logic            exp_err;
  } frame_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        hs_lo, vs_lo, hs_hi, vs_hi, blank_n;
  logic [7:0]  r, g, b;
  logic        wr_en0, wr_en1, done0, done1, err0, err1, lock0, lock1;
  logic [9:0]  h0, h1;
  logic [8:0]  v0, v1;
  logic [23:0] d0, d1, sum0, sum1;

  int unsigned cyc       = 0;
  int          n_vec     = 0;
  int          n_bad     = 0;
  bit          capturing = 1'b0;
  bit          prev_rst  = 1'b1;
  bit          cur_err   = 1'b0;
  logic [23:0] run_sum   = '0;
  bit          st_err [2];
  bit          st_lock[2];
  wr_t         q0[$], q1[$];
  fr_t         f0[$], f1[$];

  always #5 clk = ~clk;

  vga_capture #(.H_ACTIVE(HA), .V_ACTIVE(VA), .SYNC_ACTIVE_LOW(1'b1)) u_dut_lo (
    .i_clk(clk), .i_rst(rst), .i_vga_hsync(hs_lo), .i_vga_vsync(vs_lo),
    .i_vga_blank_n(blank_n), .i_vga_r(r), .i_vga_g(g), .i_vga_b(b),
    .o_wr_en(wr_en0), .o_wr_h_addr(h0), .o_wr_v_addr(v0), .o_wr_data(d0),
    .o_frame_done(done0), .o_frame_err(err0),
`ifdef VGA_CAPTURE_CHECKSUM_EN
    .o_frame_sum(sum0),
`endif
    .o_locked(lock0)
  );

  vga_capture #(.H_ACTIVE(HA), .V_ACTIVE(VA), .SYNC_ACTIVE_LOW(1'b0)) u_dut_hi (
    .i_clk(clk), .i_rst(rst), .i_vga_hsync(hs_hi), .i_vga_vsync(vs_hi),
    .i_vga_blank_n(blank_n), .i_vga_r(r), .i_vga_g(g), .i_vga_b(b),
    .o_wr_en(wr_en1), .o_wr_h_addr(h1), .o_wr_v_addr(v1), .o_wr_data(d1),
    .o_frame_done(done1), .o_frame_err(err1),
`ifdef VGA_CAPTURE_CHECKSUM_EN
    .o_frame_sum(sum1),
`endif
    .o_locked(lock1)
  );

`ifndef VGA_CAPTURE_CHECKSUM_EN
  assign sum0 = '0;
  assign sum1 = '0;
`endif

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic pop_wr(input int k, output wr_t e, output bit ok);
    ok = 1'b0;
    e  = '0;
    if (k == 0) begin
      if (q0.size() > 0) begin e = q0.pop_front(); ok = 1'b1; end
    end else begin
      if (q1.size() > 0) begin e = q1.pop_front(); ok = 1'b1; end
    end
  endtask

  task automatic pop_fr(input int k, output fr_t f, output bit ok);
    ok = 1'b0;
    f  = '0;
    if (k == 0) begin
      if (f0.size() > 0) begin f = f0.pop_front(); ok = 1'b1; end
    end else begin
      if (f1.size() > 0) begin f = f1.pop_front(); ok = 1'b1; end
    end
  endtask

  function automatic bit wr_overdue(input int k);
    if (k == 0) return (q0.size() > 0) && (q0[0].cyc < cyc);
    return (q1.size() > 0) && (q1[0].cyc < cyc);
  endfunction

  function automatic bit fr_overdue(input int k);
    if (k == 0) return (f0.size() > 0) && (f0[0].cyc < cyc);
    return (f1.size() > 0) && (f1[0].cyc < cyc);
  endfunction

  task automatic chk_dut(input int k, input logic en, input logic [9:0] h, input logic [8:0] v,
                         input logic [23:0] d, input logic done, input logic ferr,
                         input logic lk, input logic [23:0] sm);
    wr_t e;
    fr_t f;
    bit  ok;
    if (prev_rst) begin
      check($sformatf("reset_state_dut%0d", k), 96'({en, done, ferr, lk, h, v, d, sm}), 96'd0);
      st_err[k]  = 1'b0;
      st_lock[k] = 1'b0;
    end
    if (en) begin
      pop_wr(k, e, ok);
      if (!ok) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_write_dut%0d: got h=%0d v=%0d data=%06h at cycle %0d, required no write",
                 k, h, v, d, cyc);
      end else begin
        check($sformatf("write_dut%0d {h,v,data,cycle}", k), 96'({h, v, d, cyc}),
              96'({e.h, e.v, e.d, e.cyc}));
      end
    end else if (wr_overdue(k)) begin
      pop_wr(k, e, ok);
      n_vec++;
      n_bad++;
      $display("FAIL missing_write_dut%0d: got no write by cycle %0d, required h=%0d v=%0d at cycle %0d",
               k, cyc, e.h, e.v, e.cyc);
    end
    if (done) begin
      pop_fr(k, f, ok);
      if (!ok) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_frame_done_dut%0d: got pulse at cycle %0d, required none", k, cyc);
      end else begin
        check($sformatf("frame_done_dut%0d {err,locked,cycle}", k), 96'({ferr, lk, cyc}),
              96'({f.err, ~f.err, f.cyc}));
`ifdef VGA_CAPTURE_CHECKSUM_EN
        check($sformatf("frame_sum_dut%0d", k), 96'(sm), 96'(f.sum));
`endif
        st_err[k]  = f.err;
        st_lock[k] = ~f.err;
      end
    end else if (fr_overdue(k)) begin
      pop_fr(k, f, ok);
      n_vec++;
      n_bad++;
      $display("FAIL missing_frame_done_dut%0d: got no pulse by cycle %0d, required at cycle %0d",
               k, cyc, f.cyc);
    end
    if (!prev_rst) begin
      check($sformatf("status_hold_dut%0d {err,locked}", k), 96'({ferr, lk}),
            96'({st_err[k], st_lock[k]}));
    end
  endtask

  // Drive one pixel-clock cycle of stimulus, then sample both instances mid-cycle.
  task automatic step(input logic s_rst, input logic s_hs, input logic s_vs, input logic s_bl,
                      input logic [23:0] rgb, input bit push, input int h, input int v);
    wr_t e;
    rst       = s_rst;
    hs_lo     = ~s_hs;
    vs_lo     = ~s_vs;
    hs_hi     = s_hs;
    vs_hi     = s_vs;
    blank_n   = s_bl;
    {r, g, b} = rgb;
    if (push) begin
      e.h   = 10'(h);
      e.v   = 9'(v);
      e.d   = rgb;
      e.cyc = cyc + 2;
      q0.push_back(e);
      q1.push_back(e);
      run_sum = run_sum + rgb;
    end
    @(negedge clk);
    chk_dut(0, wr_en0, h0, v0, d0, done0, err0, lock0, sum0);
    chk_dut(1, wr_en1, h1, v1, d1, done1, err1, lock1, sum1);
    prev_rst = s_rst;
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 1'b0, 1'b0, 24'h0, 1'b0, 0, 0);
  endtask

  task automatic line_tail();
    idle(2);
    repeat (2) step(1'b0, 1'b1, 1'b0, 1'b0, 24'h0, 1'b0, 0, 0);
    idle(2);
  endtask

  task automatic line(input int l, input int n, input bit ovl, input logic [1:0] mode);
    logic [23:0] d;
    for (int h = 0; h < n; h++) begin
      d = (mode == 2'd0) ? 24'(l * 16 + h) : (mode == 2'd1) ? 24'h000001 : 24'hFFFFFF;
      step(1'b0, ovl && (h == n - 1), 1'b0, 1'b1, d, capturing && (h < HA) && (l < VA), h, l);
    end
    line_tail();
  endtask

  // The vsync rise closes the previous captured frame; its result is due 2 cycles later.
  task automatic vsync_pulse();
    fr_t f;
    if (capturing) begin
      f.err = cur_err;
      f.sum = run_sum;
      f.cyc = cyc + 2;
      f0.push_back(f);
      f1.push_back(f);
    end
    repeat (3) step(1'b0, 1'b0, 1'b1, 1'b0, 24'h0, 1'b0, 0, 0);
    idle(3);
    capturing = 1'b1;
    run_sum   = '0;
  endtask

  task automatic run_frame(input frame_t f);
    vsync_pulse();
    cur_err = f.exp_err;
    for (int l = 0; l < int'(f.nlines); l++) begin
      line(l, int'(f.npix[l]), f.hs_ovl && (l == 1), f.mode);
    end
  endtask

  function automatic frame_t mk(input int nl, input int p0, input int p1, input int p2,
                                input int p3, input int p4, input bit ovl, input int mode,
                                input bit err);
    frame_t f;
    f.nlines  = 4'(nl);
    f.npix[0] = 4'(p0);
    f.npix[1] = 4'(p1);
    f.npix[2] = 4'(p2);
    f.npix[3] = 4'(p3);
    f.npix[4] = 4'(p4);
    f.npix[5] = 4'(0);
    f.hs_ovl  = ovl;
    f.mode    = 2'(mode);
    f.exp_err = err;
    return f;
  endfunction

  initial begin
    frame_t tbl[9];
    //           lines  line pixel counts  ovl mode err
    tbl[0] = mk(4,     8, 8, 8, 8, 0,     0,  0,   0);  // nominal
    tbl[1] = mk(4,     8, 8, 7, 8, 0,     0,  0,   1);  // short line 2
    tbl[2] = mk(4,     8, 8, 8, 8, 0,     0,  0,   0);  // clean frame restores lock
    tbl[3] = mk(5,     9, 8, 8, 8, 8,     0,  0,   1);  // long line 0 and an extra line
    tbl[4] = mk(4,     8, 8, 8, 8, 0,     1,  0,   1);  // blank_n high during hsync
    tbl[5] = mk(4,     8, 8, 8, 8, 0,     0,  0,   0);  // nominal
    tbl[6] = mk(1,     2, 0, 0, 0, 0,     0,  2,   1);  // two 24'hFFFFFF pixels, sum wraps
    tbl[7] = mk(4,     8, 8, 8, 8, 0,     0,  1,   0);  // all pixels 24'h000001, sum 32
    tbl[8] = mk(4,     8, 8, 8, 8, 0,     0,  0,   0);  // first frame after mid-frame reset
    st_err  = '{1'b0, 1'b0};
    st_lock = '{1'b0, 1'b0};
    rst     = 1'b1;
    hs_lo   = 1'b1;
    vs_lo   = 1'b1;
    hs_hi   = 1'b0;
    vs_hi   = 1'b0;
    blank_n = 1'b0;
    {r, g, b} = 24'h0;
    @(posedge clk);
    #1;
    repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0, 24'h0, 1'b0, 0, 0);

    // Partial frame seen before any vsync: never written.
    line(0, HA, 1'b0, 2'd0);
    line(1, HA, 1'b0, 2'd0);

    for (int i = 0; i < 8; i++) run_frame(tbl[i]);

    // Frame interrupted by reset in the middle of line 1.
    vsync_pulse();
    line(0, HA, 1'b0, 2'd0);
    for (int h = 0; h < 3; h++) step(1'b0, 1'b0, 1'b0, 1'b1, 24'(16 + h), 1'b1, h, 1);
    // Still in the pipeline when reset lands, so it is discarded.
    step(1'b0, 1'b0, 1'b0, 1'b1, 24'h000013, 1'b0, 3, 1);
    capturing = 1'b0;
    repeat (3) step(1'b1, 1'b0, 1'b0, 1'b1, 24'h0ABCDE, 1'b0, 0, 0);
    for (int h = 4; h < HA; h++) step(1'b0, 1'b0, 1'b0, 1'b1, 24'(16 + h), 1'b0, h, 1);
    line_tail();
    line(2, HA, 1'b0, 2'd0);
    line(3, HA, 1'b0, 2'd0);

    run_frame(tbl[8]);
    vsync_pulse();
    idle(8);

    check("writes_outstanding_dut0", 96'(q0.size()), 96'd0);
    check("writes_outstanding_dut1", 96'(q1.size()), 96'd0);
    check("frames_outstanding_dut0", 96'(f0.size()), 96'd0);
    check("frames_outstanding_dut1", 96'(f1.size()), 96'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
